// File: rtl/usb_upload_arbiter.sv
// Round-robin burst scheduler feeding N_SRC channel FIFOs into the shared USB upload FIFO.
// Every burst is prefixed by one {tag, source, length} header word; flush drains partial bursts.
module usb_upload_arbiter #(
  parameter int unsigned N_SRC      = 4,
  parameter int unsigned BURST_LEN  = 64,
  parameter logic [3:0]  HEADER_TAG = 4'hA
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Acq_Start_Stop,
  input  logic [N_SRC*14-1:0] src_rd_data_count,
  input  logic [N_SRC*16-1:0] src_dout,
  output logic [N_SRC-1:0]    src_rd_en,
  input  logic                out_full,
  output logic                out_wr_en,
  output logic [15:0]         out_din,
  output logic [1:0]          cur_src,
  output logic                busy,
  output logic                flush_done
);

  localparam int unsigned CNT_W = 14;
  localparam int unsigned DAT_W = 16;
  localparam int unsigned LEN_W = 10;
  localparam int unsigned SRC_W = 2;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_HEADER = 2'd1,
    ARB_BURST  = 2'd2,
    ARB_DONE   = 2'd3
  } arb_state_e;

  arb_state_e         state_q, state_d;
  logic [SRC_W-1:0]   g_q, g_d;
  logic [SRC_W-1:0]   ptr_q, ptr_d;
  logic [LEN_W-1:0]   left_q, left_d;
  logic [DAT_W-1:0]   hdr_q, hdr_d;
  logic [SRC_W-1:0]   cur_src_q, cur_src_d;
  logic [N_SRC-1:0]   rd_en_q, rd_en_d;
  logic               wr_en_q, wr_en_d;
  logic               busy_q, busy_d;
  logic               flush_done_q, flush_done_d;

  logic [CNT_W-1:0]   cnt_a  [N_SRC];
  logic [DAT_W-1:0]   dout_a [N_SRC];
  logic [N_SRC-1:0]   elig;
  logic               grant_vld;
  logic [SRC_W-1:0]   grant;
  logic [SRC_W-1:0]   cand;
  logic [LEN_W-1:0]   grant_len;

  // Per-source views of the flattened buses and eligibility for the current mode.
  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    assign cnt_a[i]  = src_rd_data_count[CNT_W*i +: CNT_W];
    assign dout_a[i] = src_dout[DAT_W*i +: DAT_W];
    assign elig[i]   = Acq_Start_Stop ? (cnt_a[i] >= CNT_W'(BURST_LEN))
                                      : (cnt_a[i] != '0);
  end

  // First eligible source after the last one served; flush bursts shrink to the available count.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    cand      = '0;
    for (int k = 1; k <= int'(N_SRC); k++) begin
      cand = SRC_W'((32'(ptr_q) + 32'(k)) % N_SRC);
      if (!grant_vld && elig[cand]) begin
        grant_vld = 1'b1;
        grant     = cand;
      end
    end
    grant_len = LEN_W'(BURST_LEN);
    if (!Acq_Start_Stop && (cnt_a[grant] < CNT_W'(BURST_LEN)))
      grant_len = LEN_W'(cnt_a[grant]);
  end

  // left counts data writes still owed; a read is issued while more than one write remains ahead.
  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    ptr_d     = ptr_q;
    left_d    = left_q;
    hdr_d     = hdr_q;
    cur_src_d = cur_src_q;

    case (state_q)
      ARB_IDLE: begin
        if (!out_full && grant_vld) begin
          state_d   = ARB_HEADER;
          g_d       = grant;
          left_d    = grant_len;
          cur_src_d = grant;
          hdr_d     = {HEADER_TAG, grant, grant_len};
        end
      end
      ARB_HEADER: state_d = ARB_BURST;
      ARB_BURST: begin
        left_d = left_q - LEN_W'(1);
        if (left_q == LEN_W'(1))
          state_d = ARB_DONE;
      end
      ARB_DONE: begin
        ptr_d   = g_q;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase

    wr_en_d = (state_d == ARB_HEADER) || (state_d == ARB_BURST);
    busy_d  = (state_d != ARB_IDLE);
    rd_en_d = '0;
    if ((state_d == ARB_HEADER) || ((state_d == ARB_BURST) && (left_d > LEN_W'(1))))
      rd_en_d[g_d] = 1'b1;
    flush_done_d = !Acq_Start_Stop && (src_rd_data_count == '0) && (state_q == ARB_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      g_q          <= '0;
      ptr_q        <= SRC_W'(N_SRC - 1);
      left_q       <= '0;
      hdr_q        <= '0;
      cur_src_q    <= '0;
      rd_en_q      <= '0;
      wr_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      g_q          <= g_d;
      ptr_q        <= ptr_d;
      left_q       <= left_d;
      hdr_q        <= hdr_d;
      cur_src_q    <= cur_src_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      busy_q       <= busy_d;
      flush_done_q <= flush_done_d;
    end
  end

  // Data must pass straight through: the source FIFO already spends the one cycle of latency.
  always_comb begin
    out_din = '0;
    if (state_q == ARB_HEADER)
      out_din = hdr_q;
    else if (state_q == ARB_BURST)
      out_din = dout_a[g_q];
  end

  assign src_rd_en  = rd_en_q;
  assign out_wr_en  = wr_en_q;
  assign cur_src    = cur_src_q;
  assign busy       = busy_q;
  assign flush_done = flush_done_q;

endmodule

// File: tb/tb_usb_upload_arbiter.sv
// Bench for usb_upload_arbiter: emulated channel FIFOs, packet-level reference model and scoreboard.
`timescale 1ns/1ps
module tb_usb_upload_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned BL = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic            acq;
  logic            out_full;
  logic [N*14-1:0] cnt_bus  = '0;
  logic [N*16-1:0] dout_bus = '0;
  logic [N-1:0]    rd_en;
  logic            wr_en;
  logic [15:0]     din;
  logic [1:0]      cur_src;
  logic            busy;
  logic            flush_done;

  always #5 clk = ~clk;

  usb_upload_arbiter #(.N_SRC(N), .BURST_LEN(BL), .HEADER_TAG(4'hA)) dut (
    .clk              (clk),
    .reset            (reset),
    .Acq_Start_Stop   (acq),
    .src_rd_data_count(cnt_bus),
    .src_dout         (dout_bus),
    .src_rd_en        (rd_en),
    .out_full         (out_full),
    .out_wr_en        (wr_en),
    .out_din          (din),
    .cur_src          (cur_src),
    .busy             (busy),
    .flush_done       (flush_done)
  );

  typedef struct packed {
    logic        hdr;
    logic [15:0] w;
  } exp_t;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] fifo_q [N][$];
  logic [15:0] mdata  [N][$];
  exp_t        exp_q[$];
  exp_t        e;
  int unsigned seq [N];
  int          mptr = N - 1;
  bit          in_reset = 1'b1;
  bit          exact_gap = 1'b0;
  int          idle_run = 100;
  int          words_in_pkt = 0;
  int          pkts_seen = 0;
  logic [15:0] last_hdr = '0;
  logic        prev_wr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Channel FIFO emulation: standard (non-FWFT) read, data valid the cycle after rd_en.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rd_en[i]) begin
        chk("rd_nonempty", 32'(fifo_q[i].size() != 0), 1);
        if (fifo_q[i].size() != 0)
          dout_bus[16*i +: 16] <= fifo_q[i].pop_front();
      end
      cnt_bus[14*i +: 14] <= 14'(fifo_q[i].size());
    end
  end

  // Scoreboard monitor: every upload write pops one expected word.
  always @(negedge clk) begin
    if (!in_reset) begin
      if (rd_en != '0)
        chk("rd_onehot", 32'($onehot(rd_en)), 1);
      if (wr_en) begin
        chk("busy_on_write", 32'(busy), 1);
        chk("write_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          if (e.hdr) begin
            chk("header", 32'(din), 32'(e.w));
            chk("hdr_cur_src", 32'(cur_src), 32'(e.w[11:10]));
            if (exact_gap && pkts_seen > 0)
              chk("gap_exact", 32'(idle_run), 2);
            else
              chk("gap_min", 32'(idle_run >= 2), 1);
            last_hdr     = din;
            words_in_pkt = 0;
            pkts_seen++;
          end else begin
            chk("data", 32'(din), 32'(e.w));
            chk("no_bubble", 32'(prev_wr), 1);
            words_in_pkt++;
          end
        end
        idle_run = 0;
      end else begin
        idle_run++;
      end
      prev_wr = wr_en;
    end
  end

  task automatic push_src(input int i, input int n);
    logic [15:0] w;
    for (int k = 0; k < n; k++) begin
      w = {2'(i), 14'(seq[i])};
      seq[i]++;
      fifo_q[i].push_back(w);
      mdata[i].push_back(w);
    end
  endtask

  // Reference model: replay the round-robin rules over the known FIFO contents.
  task automatic plan();
    bit          found;
    int          g;
    int          len;
    int          c;
    logic [15:0] w;
    exp_t        x;
    do begin
      found = 1'b0;
      g = 0;
      for (int k = 1; k <= N; k++) begin
        c = (mptr + k) % N;
        if (!found && (acq ? (mdata[c].size() >= BL) : (mdata[c].size() >= 1))) begin
          found = 1'b1;
          g = c;
        end
      end
      if (found) begin
        len = (mdata[g].size() < BL) ? mdata[g].size() : BL;
        x.hdr = 1'b1;
        x.w   = {4'hA, 2'(g), 10'(len)};
        exp_q.push_back(x);
        for (int k = 0; k < len; k++) begin
          w = mdata[g].pop_front();
          x.hdr = 1'b0;
          x.w   = w;
          exp_q.push_back(x);
        end
        mptr = g;
      end
    end while (found);
  endtask

  task automatic wait_drain(input bit rand_full);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      @(posedge clk); #1;
      if (rand_full) out_full = ($urandom_range(0, 2) == 0);
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 0);
    exp_q.delete();
    out_full = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_reset = 1'b1;
    reset    = 1'b1;
    #1;
    chk("rst_async_wr_en", 32'(wr_en), 0);
    chk("rst_async_rd_en", 32'(rd_en), 0);
    chk("rst_async_busy", 32'(busy), 0);
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      fifo_q[i].delete();
      mdata[i].delete();
    end
    mptr = N - 1;
    repeat (2) @(posedge clk);
    #1;
    reset        = 1'b0;
    idle_run     = 100;
    prev_wr      = 1'b0;
    words_in_pkt = 0;
    pkts_seen    = 0;
    in_reset     = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    reset    = 1'b1;
    acq      = 1'b0;
    out_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_flush_done", 32'(flush_done), 0);
    chk("rst_cur_src", 32'(cur_src), 0);
    chk("rst_out_din", 32'(din), 0);

    acq = 1'b1;
    reset = 1'b0;
    in_reset = 1'b0;
    @(posedge clk); #1;

    // Single full burst from src0.
    push_src(0, 64);
    plan();
    wait_drain(1'b0);
    chk("t1_header", 32'(last_hdr), 32'h0000_A040);
    chk("t1_cur_src", 32'(cur_src), 0);
    chk("t1_busy_idle", 32'(busy), 0);
    chk("t1_flush_done", 32'(flush_done), 0);

    // All sources loaded: strict rotation from src0 with 2-cycle gaps.
    do_reset();
    for (int i = 0; i < N; i++) push_src(i, 200);
    exact_gap = 1'b1;
    plan();
    wait_drain(1'b0);
    exact_gap = 1'b0;
    chk("t2_packets", 32'(pkts_seen), 12);

    // Back-pressure holds src1 off until out_full drops.
    out_full = 1'b1;
    push_src(1, 64);
    plan();
    repeat (10) begin
      @(posedge clk); #1;
      chk("full_no_wr", 32'(wr_en), 0);
      chk("full_no_rd", 32'(rd_en), 0);
    end
    out_full = 1'b0;
    n = 0;
    while (!wr_en && n < 4) begin
      @(posedge clk); #1;
      n++;
    end
    chk("full_release_wr", 32'(wr_en), 1);
    chk("full_release_hdr", 32'(din), 32'h0000_A440);
    wait_drain(1'b0);

    // Flush the 8-word leftovers, then a lone 5-word partial from src2.
    acq = 1'b0;
    plan();
    wait_drain(1'b0);
    chk("t4_flush_done_a", 32'(flush_done), 1);
    push_src(2, 5);
    plan();
    repeat (2) @(posedge clk);
    #1;
    chk("t4_flush_pending", 32'(flush_done), 0);
    wait_drain(1'b0);
    chk("t4_header", 32'(last_hdr), 32'h0000_A805);
    chk("t4_flush_done_b", 32'(flush_done), 1);
    acq = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("acq_clears_flush_done", 32'(flush_done), 0);

    // Reset in the middle of a burst truncates it; src0 then has first priority.
    words_in_pkt = 0;
    push_src(3, 64);
    plan();
    n = 0;
    while (words_in_pkt < 10 && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    chk("t5_reached_word10", 32'(words_in_pkt >= 10), 1);
    do_reset();
    for (int i = 0; i < N; i++) push_src(i, 64);
    plan();
    wait_drain(1'b0);
    chk("t5_last_src", 32'(cur_src), 3);

    // Random loads with random back-pressure, each round followed by a flush.
    for (int r = 0; r < 3; r++) begin
      acq = 1'b1;
      for (int i = 0; i < N; i++) push_src(i, int'($urandom_range(0, 300)));
      plan();
      wait_drain(1'b1);
      acq = 1'b0;
      plan();
      wait_drain(1'b1);
      chk("rand_flush_done", 32'(flush_done), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
